// File: rtl/truth_table_sweeper.sv
// Purpose: sweeps all 2**N_IN input vectors into a combinational DUT, captures its truth table and grades it against EXPECTED.
// Latency: done is high in the cycle after edge 1+2**N_IN*SETTLE, counting the start-sampling edge as edge 1.
// Backpressure: none; start is honoured only in IDLE and never queued, abort cancels an active sweep on the next edge.
module truth_table_sweeper #(
    parameter int                      N_IN     = 3,
    parameter int                      SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0]    EXPECTED = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       f_in,
    output logic [N_IN-1:0]            vec,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [(1<<N_IN)-1:0]       tt,
    output logic [N_IN:0]              fail_cnt,
    output logic                       fail_vld,
    output logic [N_IN-1:0]            fail_idx
);

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   FCNT_ONE = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            start_ok;
    logic            sample;
    logic            mism;
    logic            last_pass;

    // A vector mismatches when the sampled DUT output differs from the golden bit.
    assign mism      = (f_in != EXPECTED[vec]);
    // Pass decision at the final sample must include that sample's own outcome.
    assign last_pass = (fail_cnt == '0) && !mism;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-derived busy/done strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        start_ok  = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_ok  = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    sample = 1'b1;
                    if (vec == VEC_LAST) begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector stepping, settle counting, truth-table capture and mismatch bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec      <= '0;
            cnt      <= '0;
            pass     <= 1'b0;
            tt       <= '0;
            fail_cnt <= '0;
            fail_vld <= 1'b0;
            fail_idx <= '0;
        end else begin
            if (start_ok) begin
                vec      <= '0;
                cnt      <= CNT_LOAD;
                pass     <= 1'b0;
                tt       <= '0;
                fail_cnt <= '0;
                fail_vld <= 1'b0;
                fail_idx <= '0;
            end
            if (busy && abort) begin
                // Partial tt and fail_* are deliberately kept for debug.
                vec  <= '0;
                pass <= 1'b0;
            end else if (busy && !sample) begin
                cnt <= cnt - CNT_ONE;
            end else if (sample) begin
                tt[vec] <= f_in;
                if (mism) begin
                    fail_cnt <= fail_cnt + FCNT_ONE;
                    if (!fail_vld) begin
                        fail_idx <= vec;
                        fail_vld <= 1'b1;
                    end
                end
                if (vec == VEC_LAST) begin
                    pass <= last_pass;
                end else begin
                    vec <= vec + VEC_ONE;
                    cnt <= CNT_LOAD;
                end
            end
            if (done) begin
                vec <= '0;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    localparam logic [7:0] GOLD  = 8'hE8;
    localparam logic [3:0] GOLD2 = 4'h6;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       f_in;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] tt;
    logic [3:0] fail_cnt;
    logic       fail_vld;
    logic [2:0] fail_idx;

    logic       start2;
    logic       abort2;
    logic       f2;
    logic [1:0] vec2;
    logic       busy2;
    logic       done2;
    logic       pass2;
    logic [3:0] tt2;
    logic [2:0] fail_cnt2;
    logic       fail_vld2;
    logic [1:0] fail_idx2;

    logic [7:0] dut_tbl;
    int         edge_cnt;
    int         checks;
    int         failures;
    logic       prev_done;

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [3:0] fcnt;
        logic       fvld;
        logic [2:0] fidx;
        int         done_edge;
    } exp_t;

    exp_t exp_q[$];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(GOLD)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .f_in     (f_in),
        .vec      (vec),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .tt       (tt),
        .fail_cnt (fail_cnt),
        .fail_vld (fail_vld),
        .fail_idx (fail_idx)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECTED(GOLD2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .abort    (abort2),
        .f_in     (f2),
        .vec      (vec2),
        .busy     (busy2),
        .done     (done2),
        .pass     (pass2),
        .tt       (tt2),
        .fail_cnt (fail_cnt2),
        .fail_vld (fail_vld2),
        .fail_idx (fail_idx2)
    );

    // Behavioural DUTs: a lookup table for the 3-input function, XOR for the 2-input one.
    assign f_in = dut_tbl[vec];
    assign f2   = vec2[1] ^ vec2[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result of a complete sweep, from the table the DUT implements.
    function automatic exp_t model(input logic [7:0] tbl);
        exp_t       e;
        logic [7:0] mask;
        mask   = tbl ^ GOLD;
        e.tt   = tbl;
        e.pass = (mask == 8'h00);
        e.fcnt = 4'($countones(mask));
        e.fvld = (mask != 8'h00);
        e.fidx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) e.fidx = 3'(i);
        end
        e.done_edge = 0;
        return e;
    endfunction

    // Monitor: every done pulse pops one expected result and is checked against it.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_single_cycle", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_edge", 32'(edge_cnt), 32'(e.done_edge));
                chk("tt", 32'(tt), 32'(e.tt));
                chk("pass", 32'(pass), 32'(e.pass));
                chk("fail_cnt", 32'(fail_cnt), 32'(e.fcnt));
                chk("fail_vld", 32'(fail_vld), 32'(e.fvld));
                if (e.fvld) chk("fail_idx", 32'(fail_idx), 32'(e.fidx));
            end
        end
        prev_done = done;
    end

    task automatic wait_vec(input logic [2:0] v);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vec == v) break;
        end
        chk("reach_vec", 32'(vec), 32'(v));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("sweep_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Full sweep; optionally re-pulses start at vec==2 to show it is ignored.
    task automatic run_sweep(input logic [7:0] tbl, input bit restart_mid);
        exp_t e;
        dut_tbl = tbl;
        e = model(tbl);
        @(negedge clk);
        e.done_edge = edge_cnt + 1 + 16;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (restart_mid) begin
            wait_vec(3'd2);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain();
        repeat (3) @(negedge clk);
        chk("tt_held", 32'(tt), 32'(e.tt));
        chk("pass_held", 32'(pass), 32'(e.pass));
        chk("idle_vec", 32'(vec), 32'd0);
    endtask

    initial begin
        int start_edge2;
        logic [7:0] tbl;
        checks    = 0;
        failures  = 0;
        edge_cnt  = 0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        start2    = 1'b0;
        abort2    = 1'b0;
        dut_tbl   = 8'h00;

        #3;
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_tt", 32'(tt), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_fail_vld", 32'(fail_vld), 32'd0);
        chk("rst_fail_idx", 32'(fail_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Majority function, then stuck-at-0, then random tables.
        run_sweep(8'hE8, 1'b0);
        run_sweep(8'h00, 1'b0);
        for (int n = 0; n < 6; n++) begin
            run_sweep(8'($urandom_range(0, 255)), 1'b0);
        end

        // Abort at vec==4: partial results held, no done.
        tbl = 8'($urandom_range(0, 255));
        dut_tbl = tbl;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec(3'd4);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vec", 32'(vec), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_tt_lo", 32'(tt[3:0]), 32'(tbl[3:0]));
        chk("abort_fail_cnt", 32'(fail_cnt), 32'($countones((tbl ^ GOLD) & 8'h0F)));
        @(negedge clk);
        abort = 1'b0;
        repeat (20) @(negedge clk);

        // Start re-pulsed mid-sweep is ignored; done timing unchanged.
        run_sweep(8'($urandom_range(0, 255)), 1'b1);

        // start together with abort in IDLE does not start a sweep.
        tbl = tt;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("start_abort_tt", 32'(tt), 32'(tbl));

        // Asynchronous reset mid-sweep at vec==5.
        dut_tbl = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec(3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vec", 32'(vec), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tt", 32'(tt), 32'd0);
        chk("arst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("arst_fail_vld", 32'(fail_vld), 32'd0);
        chk("arst_fail_idx", 32'(fail_idx), 32'd0);
        chk("arst_pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(8'($urandom_range(0, 255)), 1'b0);

        // Two-input XOR against golden 4'h6 with SETTLE=1.
        @(negedge clk);
        start_edge2 = edge_cnt + 1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done2) break;
            @(negedge clk);
        end
        chk("x2_done", 32'(done2), 32'd1);
        chk("x2_done_edge", 32'(edge_cnt), 32'(start_edge2 + 4));
        chk("x2_tt", 32'(tt2), 32'(GOLD2));
        chk("x2_pass", 32'(pass2), 32'd1);
        chk("x2_fail_cnt", 32'(fail_cnt2), 32'd0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
